// File: rtl/bit_deserializer16_if.sv
// Serial-in / word-out bundle for bit_deserializer16.
// master: the side feeding bits and consuming words; slave: the deserializer.
interface bit_deserializer16_if;
  logic        DIN;
  logic        DIN_DV;
  logic        FLUSH;
  logic        DOUT_RDY;
  logic [15:0] DOUT;
  logic [4:0]  DOUT_CNT;
  logic        DOUT_DV;
  logic        OVF;

  modport master (
    output DIN, DIN_DV, FLUSH, DOUT_RDY,
    input  DOUT, DOUT_CNT, DOUT_DV, OVF
  );

  modport slave (
    input  DIN, DIN_DV, FLUSH, DOUT_RDY,
    output DOUT, DOUT_CNT, DOUT_DV, OVF
  );
endinterface

// File: rtl/bit_deserializer16.sv
// Packs a qualified serial bit stream into 16-bit words with a one-word output slot,
// partial-word flush and a sticky overflow flag for words dropped on a busy slot.
module bit_deserializer16 #(
  parameter bit LSB_FIRST = 1'b1
) (
  input logic               CLK,
  input logic               RST,
  bit_deserializer16_if.slave bus
);

  logic [15:0] col_p0;
  logic [3:0]  fcnt_p0;
  logic [15:0] dout_p1;
  logic [4:0]  cnt_p1;
  logic        vld_p1;
  logic        ovf_p1;

  logic        acc;
  logic        slot_free;
  logic        complete;
  logic        flush_go;
  logic [3:0]  pos;
  logic [15:0] col_next;
  logic [4:0]  fill_next;

  function automatic logic [15:0] place_bit(input logic [15:0] w, input logic [3:0] p,
                                            input logic d);
    logic [15:0] r;
    r    = w;
    r[p] = d;
    return r;
  endfunction

  always_comb begin
    acc       = bus.DIN_DV;
    slot_free = !vld_p1 || bus.DOUT_RDY;
    pos       = LSB_FIRST ? fcnt_p0 : (4'd15 - fcnt_p0);
    col_next  = acc ? place_bit(col_p0, pos, bus.DIN) : col_p0;
    complete  = acc && (fcnt_p0 == 4'd15);
    // A completing 16th bit always wins over a same-edge flush.
    flush_go  = bus.FLUSH && slot_free && ((fcnt_p0 != 4'd0) || acc) && !complete;
    fill_next = {1'b0, fcnt_p0} + {4'b0000, acc};
  end

  // p0 collect stage -> p1 output slot
  always_ff @(posedge CLK) begin
    if (RST) begin
      col_p0  <= '0;
      fcnt_p0 <= '0;
      dout_p1 <= '0;
      cnt_p1  <= '0;
      vld_p1  <= 1'b0;
      ovf_p1  <= 1'b0;
    end else if (complete) begin
      if (slot_free) begin
        dout_p1 <= col_next;
        cnt_p1  <= 5'd16;
        vld_p1  <= 1'b1;
      end else begin
        ovf_p1  <= 1'b1;
      end
      col_p0  <= '0;
      fcnt_p0 <= '0;
    end else if (flush_go) begin
      dout_p1 <= col_next;
      cnt_p1  <= fill_next;
      vld_p1  <= 1'b1;
      col_p0  <= '0;
      fcnt_p0 <= '0;
    end else begin
      if (acc) begin
        col_p0  <= col_next;
        fcnt_p0 <= fcnt_p0 + 4'd1;
      end
      if (vld_p1 && bus.DOUT_RDY) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.DOUT     = dout_p1;
  assign bus.DOUT_CNT = cnt_p1;
  assign bus.DOUT_DV  = vld_p1;
  assign bus.OVF      = ovf_p1;

endmodule

// File: tb/tb_bit_deserializer16.sv
// Directed bench for bit_deserializer16: one LSB-first and one MSB-first instance.
module tb_bit_deserializer16;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  bit_deserializer16_if ia ();
  bit_deserializer16_if ib ();

  bit_deserializer16 #(.LSB_FIRST(1'b1)) u_lsb (.CLK(CLK), .RST(RST), .bus(ia));
  bit_deserializer16 #(.LSB_FIRST(1'b0)) u_msb (.CLK(CLK), .RST(RST), .bus(ib));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    ia.DIN = 1'b1; ia.DIN_DV = 1'b1; ia.FLUSH = 1'b1; ia.DOUT_RDY = 1'b1;
    tick();
    RST = 1'b0;
    ia.DIN = 1'b0; ia.DIN_DV = 1'b0; ia.FLUSH = 1'b0;
    checks++; if (ia.DOUT !== 16'h0000) begin errors++; $display("FAIL reset_dout actual=%h expected=0000", ia.DOUT); end
    checks++; if (ia.DOUT_CNT !== 5'd0) begin errors++; $display("FAIL reset_cnt actual=%0d expected=0", ia.DOUT_CNT); end
    checks++; if (ia.DOUT_DV !== 1'b0) begin errors++; $display("FAIL reset_dv actual=%b expected=0", ia.DOUT_DV); end
    checks++; if (ia.OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf actual=%b expected=0", ia.OVF); end
    checks++; if (ib.DOUT_DV !== 1'b0) begin errors++; $display("FAIL reset_msb_dv actual=%b expected=0", ib.DOUT_DV); end
  endtask

  task automatic test_lsb_word();
    ia.DOUT_RDY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ia.DIN = (i % 2 == 0);
      ia.DIN_DV = 1'b1;
      tick();
      ia.DIN_DV = 1'b0;
      if (i < 15) begin
        tick();
        if (i == 14) begin
          checks++; if (ia.DOUT_DV !== 1'b0) begin errors++; $display("FAIL lsb_early_dv actual=%b expected=0", ia.DOUT_DV); end
        end
      end
    end
    checks++; if (ia.DOUT_DV !== 1'b1) begin errors++; $display("FAIL lsb_word_dv actual=%b expected=1", ia.DOUT_DV); end
    checks++; if (ia.DOUT !== 16'h5555) begin errors++; $display("FAIL lsb_word_dout actual=%h expected=5555", ia.DOUT); end
    checks++; if (ia.DOUT_CNT !== 5'd16) begin errors++; $display("FAIL lsb_word_cnt actual=%0d expected=16", ia.DOUT_CNT); end
    tick();
    checks++; if (ia.DOUT_DV !== 1'b0) begin errors++; $display("FAIL lsb_word_dv_once actual=%b expected=0", ia.DOUT_DV); end
  endtask

  task automatic test_msb_word();
    ib.DOUT_RDY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ib.DIN = (i == 0);
      ib.DIN_DV = 1'b1;
      tick();
    end
    ib.DIN_DV = 1'b0;
    checks++; if (ib.DOUT_DV !== 1'b1) begin errors++; $display("FAIL msb_word_dv actual=%b expected=1", ib.DOUT_DV); end
    checks++; if (ib.DOUT !== 16'h8000) begin errors++; $display("FAIL msb_word_dout actual=%h expected=8000", ib.DOUT); end
    checks++; if (ib.DOUT_CNT !== 5'd16) begin errors++; $display("FAIL msb_word_cnt actual=%0d expected=16", ib.DOUT_CNT); end
    tick();
    checks++; if (ib.DOUT_DV !== 1'b0) begin errors++; $display("FAIL msb_word_consumed actual=%b expected=0", ib.DOUT_DV); end
  endtask

  task automatic test_flush();
    logic [2:0] bits;
    bits = 3'b011;
    ia.DOUT_RDY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ia.DIN = bits[i];
      ia.DIN_DV = 1'b1;
      tick();
    end
    ia.DIN_DV = 1'b0;
    ia.FLUSH = 1'b1;
    tick();
    ia.FLUSH = 1'b0;
    checks++; if (ia.DOUT_DV !== 1'b1) begin errors++; $display("FAIL flush_dv actual=%b expected=1", ia.DOUT_DV); end
    checks++; if (ia.DOUT !== 16'h0003) begin errors++; $display("FAIL flush_dout actual=%h expected=0003", ia.DOUT); end
    checks++; if (ia.DOUT_CNT !== 5'd3) begin errors++; $display("FAIL flush_cnt actual=%0d expected=3", ia.DOUT_CNT); end
    // Consume-and-load on one edge; a single bit proves the fill counter restarted at 0.
    ia.DIN = 1'b1; ia.DIN_DV = 1'b1; ia.FLUSH = 1'b1;
    tick();
    ia.DIN_DV = 1'b0;
    checks++; if (ia.DOUT_DV !== 1'b1) begin errors++; $display("FAIL flush_b2b_dv actual=%b expected=1", ia.DOUT_DV); end
    checks++; if (ia.DOUT !== 16'h0001) begin errors++; $display("FAIL flush_b2b_dout actual=%h expected=0001", ia.DOUT); end
    checks++; if (ia.DOUT_CNT !== 5'd1) begin errors++; $display("FAIL flush_b2b_cnt actual=%0d expected=1", ia.DOUT_CNT); end
    tick();
    ia.FLUSH = 1'b0;
    checks++; if (ia.DOUT_DV !== 1'b0) begin errors++; $display("FAIL flush_empty_noop_dv actual=%b expected=0", ia.DOUT_DV); end
    checks++; if (ia.DOUT !== 16'h0001) begin errors++; $display("FAIL consume_keeps_dout actual=%h expected=0001", ia.DOUT); end
  endtask

  task automatic test_overflow();
    pulse_reset();
    ia.DOUT_RDY = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ia.DIN = (i % 2 == 0);
      ia.DIN_DV = 1'b1;
      tick();
      if (i == 30) begin
        checks++; if (ia.OVF !== 1'b0) begin errors++; $display("FAIL ovf_early actual=%b expected=0", ia.OVF); end
      end
    end
    ia.DIN_DV = 1'b0;
    checks++; if (ia.OVF !== 1'b1) begin errors++; $display("FAIL ovf_set actual=%b expected=1", ia.OVF); end
    checks++; if (ia.DOUT !== 16'h5555) begin errors++; $display("FAIL ovf_held_dout actual=%h expected=5555", ia.DOUT); end
    checks++; if (ia.DOUT_CNT !== 5'd16) begin errors++; $display("FAIL ovf_held_cnt actual=%0d expected=16", ia.DOUT_CNT); end
    checks++; if (ia.DOUT_DV !== 1'b1) begin errors++; $display("FAIL ovf_held_dv actual=%b expected=1", ia.DOUT_DV); end
    ia.DOUT_RDY = 1'b1;
    tick();
    checks++; if (ia.DOUT_DV !== 1'b0) begin errors++; $display("FAIL ovf_drain_dv actual=%b expected=0", ia.DOUT_DV); end
    tick();
    checks++; if (ia.OVF !== 1'b1) begin errors++; $display("FAIL ovf_sticky actual=%b expected=1", ia.OVF); end
  endtask

  task automatic test_reset_midword();
    pulse_reset();
    checks++; if (ia.OVF !== 1'b0) begin errors++; $display("FAIL ovf_rst_clear actual=%b expected=0", ia.OVF); end
    ia.DOUT_RDY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ia.DIN = 1'b0; ia.DIN_DV = 1'b1;
      tick();
    end
    ia.DIN_DV = 1'b0;
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      ia.DIN = 1'b1; ia.DIN_DV = 1'b1;
      tick();
      if (i == 7) begin
        checks++; if (ia.DOUT_DV !== 1'b0) begin errors++; $display("FAIL midrst_residue_dv actual=%b expected=0", ia.DOUT_DV); end
      end
    end
    ia.DIN_DV = 1'b0;
    ia.DOUT_RDY = 1'b0;
    checks++; if (ia.DOUT !== 16'hFFFF) begin errors++; $display("FAIL midrst_dout actual=%h expected=FFFF", ia.DOUT); end
    checks++; if (ia.DOUT_CNT !== 5'd16) begin errors++; $display("FAIL midrst_cnt actual=%0d expected=16", ia.DOUT_CNT); end
    pulse_reset();
    checks++; if (ia.DOUT_DV !== 1'b0) begin errors++; $display("FAIL rst_held_dv actual=%b expected=0", ia.DOUT_DV); end
    checks++; if (ia.DOUT !== 16'h0000) begin errors++; $display("FAIL rst_held_dout actual=%h expected=0000", ia.DOUT); end
  endtask

  task automatic test_flush_held();
    logic [4:0] part;
    part = 5'b11011;
    pulse_reset();
    ia.DOUT_RDY = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ia.DIN = (i % 2 == 0); ia.DIN_DV = 1'b1;
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      ia.DIN = part[i]; ia.DIN_DV = 1'b1;
      tick();
    end
    ia.DIN_DV = 1'b0;
    ia.FLUSH = 1'b1;
    tick();
    tick();
    checks++; if (ia.DOUT !== 16'h5555) begin errors++; $display("FAIL held_flush_dout actual=%h expected=5555", ia.DOUT); end
    checks++; if (ia.DOUT_CNT !== 5'd16) begin errors++; $display("FAIL held_flush_cnt actual=%0d expected=16", ia.DOUT_CNT); end
    ia.DOUT_RDY = 1'b1;
    tick();
    ia.DOUT_RDY = 1'b0;
    ia.FLUSH = 1'b0;
    checks++; if (ia.DOUT_DV !== 1'b1) begin errors++; $display("FAIL retry_flush_dv actual=%b expected=1", ia.DOUT_DV); end
    checks++; if (ia.DOUT !== 16'h001B) begin errors++; $display("FAIL retry_flush_dout actual=%h expected=001B", ia.DOUT); end
    checks++; if (ia.DOUT_CNT !== 5'd5) begin errors++; $display("FAIL retry_flush_cnt actual=%0d expected=5", ia.DOUT_CNT); end
    checks++; if (ia.OVF !== 1'b0) begin errors++; $display("FAIL retry_flush_ovf actual=%b expected=0", ia.OVF); end
    tick();
    checks++; if (ia.DOUT !== 16'h001B) begin errors++; $display("FAIL retry_flush_stable actual=%h expected=001B", ia.DOUT); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b1;
    ia.DIN = 1'b0; ia.DIN_DV = 1'b0; ia.FLUSH = 1'b0; ia.DOUT_RDY = 1'b0;
    ib.DIN = 1'b0; ib.DIN_DV = 1'b0; ib.FLUSH = 1'b0; ib.DOUT_RDY = 1'b0;
    test_reset();
    test_msb_word();
    test_lsb_word();
    test_flush();
    test_overflow();
    test_reset_midword();
    test_flush_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
